// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Sequential InvMixColumns stage of the AES-128 decryption datapath. A 128-bit
// state is captured into an internal buffer, then COLS_PER_CYCLE columns are
// replaced in place each clock by their product with the inverse MixColumns
// matrix [0e 0b 0d 09] over GF(2^8) (reduction polynomial 0x11b). When all four
// columns are done the buffer is presented on state_o until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   state_i carries a state to transform
//   in_ready   block can accept a state (high exactly while idle)
//   state_i    input state; column c = bits [127-32c -: 32], row 0 is the MSB byte
//   out_valid  state_o holds a finished result
//   out_ready  downstream accepts state_o
//   state_o    result state, same layout as state_i (don't-care while !out_valid)
//
// Parameter
//   COLS_PER_CYCLE  columns transformed per clock: 1, 2 or 4.
//                   Latency accept->out_valid is 4/COLS_PER_CYCLE cycles.
// -----------------------------------------------------------------------------
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fsm_t;

    // Column counter step; for COLS_PER_CYCLE=4 this is 0 and col stays at 0.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    fsm_t         fsm;
    logic [1:0]   col;
    logic [127:0] buffer;
    logic [127:0] buffer_mixed;
    logic         last_group;

    // Multiply by x in GF(2^8), reducing by 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times [0e 0b 0d 09], each row rotated right by one byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Buffer with the current column group already mixed; written back in CALC.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no path
        // leaves it unassigned (which would infer a latch).
        buffer_mixed = buffer;
        for (int c = 0; c < 4; c++) begin
            if (c >= int'(col) && c < int'(col) + COLS_PER_CYCLE) begin
                buffer_mixed[127-32*c -: 32] = inv_mix_col(buffer[127-32*c -: 32]);
            end
        end
    end

    assign last_group = (int'(col) + COLS_PER_CYCLE == 4);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            col       <= '0;
            // NOTE: the data buffer is reset too, because it drives state_o
            // directly and state_o must read zero while in reset.
            buffer    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        buffer <= state_i;
                        col    <= '0;
                        fsm    <= CALC;
                    end
                end
                CALC: begin
                    buffer <= buffer_mixed;
                    col    <= col + COL_STEP;
                    if (last_group) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (fsm == IDLE);
    assign state_o  = buffer;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_seq
//
// Self-checking bench for inv_mix_columns_seq. One instance with
// COLS_PER_CYCLE=1 carries most scenarios; instances with 2 and 4 columns per
// cycle share a second set of inputs for the latency/width scenario.
// Expected values come from a GF(2^8) matrix model built on shift-and-reduce
// polynomial multiplication.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_o;

    logic         in_valid_w;
    logic         out_ready_w;
    logic [127:0] state_i_w;
    logic         in_ready_2, out_valid_2, in_ready_4, out_valid_4;
    logic [127:0] state_o_2, state_o_4;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [31:0]  INV_COEF = 32'h0e0b0d09;
    localparam logic [31:0]  FWD_COEF = 32'h02030101;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state_i(state_i), .out_valid(out_valid), .out_ready(out_ready), .state_o(state_o)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_2),
        .state_i(state_i_w), .out_valid(out_valid_2), .out_ready(out_ready_w), .state_o(state_o_2)
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_4),
        .state_i(state_i_w), .out_valid(out_valid_4), .out_ready(out_ready_w), .state_o(state_o_4)
    );

    // ---------------- reference model ----------------
    // Carry-less product followed by polynomial reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix times every column; row r uses coef[(j - r) mod 4].
    function automatic logic [127:0] ref_apply(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] o;
        logic [7:0]   b;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = '0;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(coefs[31-8*((j-r+4)%4) -: 8], s[127-32*c-8*j -: 8]);
                o[127-32*c-8*r -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return ref_apply(s, INV_COEF);
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        return ref_apply(s, FWD_COEF);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one state into the 1-column instance and wait for out_valid.
    // lat is the number of edges after the accept edge; -1 if it never came.
    task automatic send_and_wait(input logic [127:0] d, output int lat, output logic [127:0] res);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        state_i  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                res = state_o;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int           lat_unused;
        logic         seen_valid;
        logic         lost_ready;
        lat_unused = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b state_o=%h, want 1 0 0",
                     in_ready, out_valid, state_o);
        end
        checks++;
        if (in_ready_2 !== 1'b1 || in_ready_4 !== 1'b1 || out_valid_2 !== 1'b0 || out_valid_4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_wide: rdy2=%b rdy4=%b vld2=%b vld4=%b, want 1 1 0 0",
                     in_ready_2, in_ready_4, out_valid_2, out_valid_4);
        end
        tick();
        rst = 1'b0;
        tick();

        // Accept a state, let one column be mixed, then reset between edges.
        state_i  = VEC_IN;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_accept: in_ready=%b after accept, want 0", in_ready);
        end
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_o !== 128'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_calc: out_valid=%b state_o=%h in_ready=%b, want 0 0 1",
                     out_valid, state_o, in_ready);
        end
        #2;
        rst = 1'b0;
        seen_valid = 1'b0;
        lost_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
            if (!in_ready) lost_ready = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0 || lost_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: saw out_valid=%b lost in_ready=%b, want 0 0",
                     seen_valid, lost_ready);
        end
    endtask

    task automatic test_latency_cpc1();
        int           lat;
        logic [127:0] res;
        out_ready = 1'b1;
        send_and_wait(VEC_IN, lat, res);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency_cpc1: got %0d cycles, want 4", lat);
        end
        checks++;
        if (res !== VEC_OUT) begin
            errors++;
            $display("FAIL vector_cpc1: got %h, want %h", res, VEC_OUT);
        end
        tick();
    endtask

    task automatic test_widths();
        int           lat2, lat4;
        logic [127:0] r2, r4, d, exp_v;
        int           n;
        out_ready_w = 1'b1;
        for (int v = 0; v < 12; v++) begin
            d     = (v == 0) ? VEC_IN : rand128();
            exp_v = (v == 0) ? VEC_OUT : ref_inv(d);
            n = 0;
            while (!(in_ready_2 && in_ready_4) && n < 20) begin
                tick();
                n++;
            end
            state_i_w  = d;
            in_valid_w = 1'b1;
            tick();
            in_valid_w = 1'b0;
            lat2 = -1;
            lat4 = -1;
            r2   = '0;
            r4   = '0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (out_valid_2 && lat2 < 0) begin
                    lat2 = k;
                    r2   = state_o_2;
                end
                if (out_valid_4 && lat4 < 0) begin
                    lat4 = k;
                    r4   = state_o_4;
                end
            end
            checks++;
            if (lat2 !== 2 || lat4 !== 1) begin
                errors++;
                $display("FAIL width_latency[%0d]: cpc2=%0d cpc4=%0d cycles, want 2 1", v, lat2, lat4);
            end
            checks++;
            if (r2 !== exp_v) begin
                errors++;
                $display("FAIL width_result_cpc2[%0d]: got %h, want %h", v, r2, exp_v);
            end
            checks++;
            if (r4 !== exp_v) begin
                errors++;
                $display("FAIL width_result_cpc4[%0d]: got %h, want %h", v, r4, exp_v);
            end
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [127:0] res, snap, d1, d2;
        logic         got2;
        d1 = rand128();
        d2 = rand128();
        out_ready = 1'b0;
        send_and_wait(d1, lat, res);
        checks++;
        if (lat !== 4 || res !== ref_inv(d1)) begin
            errors++;
            $display("FAIL hold_first: lat=%0d got %h, want 4 %h", lat, res, ref_inv(d1));
        end
        snap = state_o;
        // Upstream offers the next state during the stall; it must not be taken.
        state_i  = d2;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || state_o !== snap || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: out_valid=%b state_o=%h in_ready=%b, want 1 %h 0",
                         k, out_valid, state_o, in_ready, snap);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_o !== snap) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b state_o=%h, want 0 1 %h",
                     out_valid, in_ready, state_o, snap);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_after_release: in_ready=%b one cycle after release, want 0", in_ready);
        end
        got2 = 1'b0;
        res  = '0;
        for (int k = 0; k < 10 && !got2; k++) begin
            tick();
            if (out_valid) begin
                got2 = 1'b1;
                res  = state_o;
            end
        end
        checks++;
        if (got2 !== 1'b1 || res !== ref_inv(d2)) begin
            errors++;
            $display("FAIL second_result: valid=%b got %h, want 1 %h", got2, res, ref_inv(d2));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] s   [3];
        logic [127:0] res [3];
        int           acc_cyc [3];
        int           idx, got, cyc;
        logic         acc_now;
        s[0] = {4{32'hc6c6c6c6}};
        s[1] = {4{32'h4d7ebdf8}};
        s[2] = {4{32'hf20a225c}};
        for (int i = 0; i < 3; i++) begin
            res[i]     = '0;
            acc_cyc[i] = -100;
        end
        idx = 0;
        got = 0;
        cyc = 0;
        out_ready = 1'b1;
        state_i   = s[0];
        in_valid  = 1'b1;
        while (got < 3 && cyc < 100) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                res[got] = state_o;
                got++;
            end
            if (acc_now) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                if (idx < 3) state_i = s[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 3", got);
        end
        checks++;
        if (res[0] !== {4{32'hc6c6c6c6}}) begin
            errors++;
            $display("FAIL b2b_result0: got %h, want %h", res[0], {4{32'hc6c6c6c6}});
        end
        checks++;
        if (res[1] !== {4{32'h2d26314c}}) begin
            errors++;
            $display("FAIL b2b_result1: got %h, want %h", res[1], {4{32'h2d26314c}});
        end
        checks++;
        if (res[2] !== ref_inv(s[2])) begin
            errors++;
            $display("FAIL b2b_result2: got %h, want %h", res[2], ref_inv(s[2]));
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6) begin
            errors++;
            $display("FAIL b2b_period: accept gaps %0d %0d, want 6 6",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] exp_q [$];
        logic [127:0] pend, x, want;
        int           sent, recv, cyc, bad;
        logic         hs_in, hs_out;
        sent = 0;
        recv = 0;
        cyc  = 0;
        bad  = 0;
        pend = '0;
        in_valid = 1'b0;
        while (recv < 1000 && cyc < 40000) begin
            if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
                x        = rand128();
                pend     = x;
                state_i  = ref_mix(x);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(1));
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : ~state_o;
                recv++;
                checks++;
                if (state_o !== want) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random[%0d]: got %h, want %h", recv - 1, state_o, want);
                end
            end
            if (hs_in) begin
                exp_q.push_back(pend);
                sent++;
            end
            tick();
            cyc++;
            if (hs_in) begin
                in_valid = 1'b0;
                state_i  = rand128();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv !== 1000) begin
            errors++;
            $display("FAIL random_count: received %0d results in %0d cycles, want 1000", recv, cyc);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        state_i     = '0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b0;
        state_i_w   = '0;
        #2;
        test_reset();
        test_latency_cpc1();
        test_widths();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
